rangefinder_sopc_sample_buffer: RTL

RANGEFINDER_SOPC_SAMPLE_BUFFER -- requirements
Module: rangefinder_sopc_sample_buffer

---
 rtl/rangefinder_sopc_sample_buffer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/rangefinder_sopc_sample_buffer.sv
// rangefinder_sopc_sample_buffer: triggered sample capture buffer with circular addressing.
//
// Optional feature macro: SAMPLE_BUFFER_PRETRIG_EN
//   defined   : pre-trigger ring capture, PRETRIG samples kept ahead of the trigger beat
//   undefined : DEPTH samples captured starting at the trigger beat, start_addr = 0
//
// Ports
//   clk        in   single clock for capture logic and both RAM ports
//   reset_n    in   asynchronous active-low reset
//   smp_valid  in   sample beat present on smp_data
//   smp_data   in   sample value (DATA_W)
//   trig       in   trigger, qualified by smp_valid
//   arm        in   pulse: start a capture (from IDLE or DONE)
//   abort      in   pulse: cancel, wins over arm
//   rd_en      in   read strobe
//   rd_addr    in   logical read index, 0 = oldest captured sample (ADDR_W)
//   rd_data    out  registered read data (DATA_W)
//   busy       out  capture in progress
//   done       out  capture complete, buffer contents valid
//   start_addr out  physical address of logical index 0 (ADDR_W)
module rangefinder_sopc_sample_buffer #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int PRETRIG = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    input  logic              trig,
    input  logic              arm,
    input  logic              abort,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] start_addr
);
    localparam int DEPTH = 2 ** ADDR_W;
`ifdef SAMPLE_BUFFER_PRETRIG_EN
    localparam int POST_LEN = DEPTH - PRETRIG;
    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(PRETRIG - 1);
`else
    localparam int POST_LEN = DEPTH;
`endif
    // post_cnt counts the trigger beat as 1, so the final beat is seen at POST_LEN-1
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_LEN - 1);

    if (PRETRIG < 1 || PRETRIG >= DEPTH) begin : g_bad_pretrig
        $error("PRETRIG must lie in 1..DEPTH-1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef SAMPLE_BUFFER_PRETRIG_EN
        S_FILL,
`endif
        S_WAIT_TRIG,
        S_POST,
        S_DONE
    } state_t;

`ifdef SAMPLE_BUFFER_PRETRIG_EN
    localparam state_t S_FIRST = S_FILL;
`else
    localparam state_t S_FIRST = S_WAIT_TRIG;
`endif

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] trig_start;
    logic [ADDR_W-1:0] rd_phys;
    logic              we;

    // oldest kept sample sits PRETRIG slots behind the trigger beat in the ring
`ifdef SAMPLE_BUFFER_PRETRIG_EN
    assign trig_start = wr_ptr_q - ADDR_W'(PRETRIG);
`else
    assign trig_start = wr_ptr_q;
`endif
    assign rd_phys = start_q + rd_addr;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        post_cnt_d = post_cnt_q;
        start_d    = start_q;
        busy_d     = busy_q;
        done_d     = done_q;
        we         = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d    = S_FIRST;
                    wr_ptr_d   = '0;
                    post_cnt_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end
            end
`ifdef SAMPLE_BUFFER_PRETRIG_EN
            S_FILL: begin
                if (smp_valid) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    state_d  = wr_ptr_q == FILL_LAST ? S_WAIT_TRIG : S_FILL;
                end
            end
`endif
            S_WAIT_TRIG: begin
                if (smp_valid && trig) begin
                    we         = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    start_d    = trig_start;
                    post_cnt_d = ADDR_W'(1);
                    // a one-sample post window completes on the trigger beat itself
                    state_d    = POST_LAST == '0 ? S_DONE : S_POST;
                    busy_d     = POST_LAST != '0;
                    done_d     = POST_LAST == '0;
                end
`ifdef SAMPLE_BUFFER_PRETRIG_EN
                else if (smp_valid) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
`endif
            end
            S_POST: begin
                if (smp_valid) begin
                    we         = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_q == POST_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            we      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            post_cnt_q <= '0;
            start_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            post_cnt_q <= post_cnt_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            if (rd_en) rd_data_q <= mem[rd_phys];
        end
    end

    // RAM has no reset; a same-cycle read of the written address returns old data
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= smp_data;
    end

    assign rd_data    = rd_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign start_addr = start_q;
endmodule
